ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

Pipeline register and operand-select stage sitting directly upstream of the execute ALU. It accepts one decoded instruction per cycle from decode under a valid/allowin handshake, builds the two 32-bit ALU operands and the 13-bit ALU opcode into flops, and presents them to the ALU. It also qualifies the ALU's overflow flag into a precise exception toward the memory stage, and suppresses younger instructions until the pipeline is flushed.

## Interface
- No parameters. The data width is fixed at 32 and the ALU opcode width at 13.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ds_to_es_valid  in  1  decode holds a valid instruction
- es_allowin  out  1  this stage accepts an instruction this cycle
- ds_aluop  in  13  ALU opcode; bit 12 is the overflow-trap enable, bits 11..0 are one-hot operations
- ds_rs_val, ds_rt_val  in  32  register operands, already forwarded
- ds_imm  in  16  immediate field
- ds_sa  in  5  shift amount
- ds_pc  in  32  instruction PC
- ds_src0_sel  in  2  operand 0 select: 00 = rs, 01 = zero-extended sa, 10 = pc, 11 = 0
- ds_src1_sel  in  2  operand 1 select: 00 = rt, 01 = sign-extended imm, 10 = zero-extended imm, 11 = 32'd8
- ds_dest  in  5  destination register number
- ds_wen  in  1  instruction writes a register
- flush  in  1  exception or eret redirect; kills the stage content
- es_scr0, es_scr1  out  32  registered ALU operands
- es_aluop  out  13  registered ALU opcode
- alu_overflow  in  1  overflow flag from the ALU (already gated by aluop bit 12)
- alu_result  in  32  ALU result
- ms_allowin  in  1  memory stage accepts an instruction
- es_to_ms_valid  out  1  valid instruction offered to the memory stage
- es_result  out  32  alu_result, passed through combinationally
- es_pc  out  32  registered PC
- es_dest  out  5  registered destination
- es_wen  out  1  register write enable toward the memory stage
- es_exc_ov  out  1  integer overflow exception toward the memory stage

## Operation
- State registers:
  - es_valid
  - the payload: scr0, scr1, aluop, pc, dest, wen
  - exc_block, a sticky bit.
- es_ready_go is constant 1 (single-cycle ALU).
- es_allowin = !es_valid || ms_allowin.
- Capture happens when ds_to_es_valid && es_allowin. All payload fields load together.
- Operand build happens at capture, so that the ALU inputs come straight from flops:
  - sa is zero-extended to 32 bits.
  - imm is sign- or zero-extended according to ds_src1_sel.
  - Constant 8 serves pc+8 link instructions, with src0 = pc.
- es_valid update, in priority order:
  1. reset → 0
  2. flush → 0
  3. es_allowin → ds_to_es_valid
  4. otherwise hold.
- When there is no capture, the payload holds its value. A payload that is not captured is don't-care except es_aluop, which resets to 0 so that the ALU output is 0 while idle.
- ov = es_valid && alu_overflow && !exc_block.
- es_exc_ov = ov.
- es_wen = es_valid && wen && !ov && !exc_block. An overflowing instruction never writes rd.
- es_to_ms_valid = es_valid && !exc_block. While exc_block is set, the stage swallows instructions: it still accepts them, but they are never forwarded.
- exc_block is set when ov && ms_allowin, i.e. when the faulting instruction is handed over.
- exc_block is cleared by flush or by reset. If flush and the set condition occur in the same cycle, flush wins and the bit is cleared.
- Flush takes effect regardless of ms_allowin. An instruction offered in the same cycle as flush is dropped.

## Timing
- Reset values:
  - es_valid = 0, exc_block = 0
  - es_aluop = 0, es_scr0 = 0, es_scr1 = 0
  - es_pc = 0, es_dest = 0
  - es_to_ms_valid = 0, es_wen = 0, es_exc_ov = 0
  - es_result follows alu_result; the ALU sees opcode 0, so es_result = 0.
- Latency is 1 cycle from decode capture to the operands appearing on es_scr0/es_scr1/es_aluop.
- es_result, es_wen and es_exc_ov are valid in that same cycle, combinationally through the ALU.
- Throughput is 1 instruction per cycle while ms_allowin = 1.
- Back-pressure: when ms_allowin = 0 and es_valid = 1:
  - es_allowin = 0
  - the payload and all outputs are held stable
  - decode must hold its inputs.
- Handover to the memory stage occurs on the edge where es_to_ms_valid && ms_allowin. A new capture can occur on the same edge.
- es_allowin depends combinationally on ms_allowin only. There is no path from alu_* to es_allowin.

## Test plan
- Pipelined stream:
  - Stimulus: three back-to-back instructions with ms_allowin = 1: ADD with rs = 5, rt = 7; ADDIU with rs = 1, imm = 16'hFFFF sign-extended; SLL with sa = 4, rt = 3.
  - Response: on consecutive cycles es_scr0/es_scr1 = 5/7, then 1/32'hFFFFFFFF, then 4/3. es_to_ms_valid = 1 for 3 cycles and es_wen = 1.
- Stall:
  - Stimulus: hold ms_allowin = 0 for 3 cycles while es_valid = 1.
  - Response: es_allowin = 0 and all outputs are frozen. After ms_allowin returns to 1, the held instruction is handed over exactly once.
- Overflow:
  - Stimulus: ADD with aluop[12] = 1, rs = 32'h7FFFFFFF, rt = 1; the ALU raises overflow.
  - Response: es_exc_ov = 1 and es_wen = 0. The next two accepted instructions show es_to_ms_valid = 0.
  - Then flush is pulsed: exc_block clears, and the following instruction propagates normally.
- Flush during stall:
  - Stimulus: assert flush while es_valid = 1, ms_allowin = 0 and ds_to_es_valid = 1.
  - Response: the next cycle has es_valid = 0, and the decode instruction was not captured.
- Mid-operation reset:
  - Stimulus: assert reset with es_valid = 1 and exc_block = 1.
  - Response: the next cycle shows all outputs at their reset values, es_allowin = 1, and exc_block = 0.
- Operand selects:
  - src0_sel = 10 with src1_sel = 11 and pc = 32'hBFC00010 → es_scr0/es_scr1 = 32'hBFC00010 and 8.
  - src1_sel = 10 with imm = 16'h8000 → es_scr1 = 32'h00008000.
  - src0_sel = 11 → es_scr0 = 0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// Execute-stage pipeline register: builds ALU operands/opcode into flops and
// qualifies ALU overflow into a precise exception, blocking younger work until flush.
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [12:0] ds_aluop,
  input  logic [31:0] ds_rs_val,
  input  logic [31:0] ds_rt_val,
  input  logic [15:0] ds_imm,
  input  logic [4:0]  ds_sa,
  input  logic [31:0] ds_pc,
  input  logic [1:0]  ds_src0_sel,
  input  logic [1:0]  ds_src1_sel,
  input  logic [4:0]  ds_dest,
  input  logic        ds_wen,
  input  logic        flush,
  output logic [31:0] es_scr0,
  output logic [31:0] es_scr1,
  output logic [12:0] es_aluop,
  input  logic        alu_overflow,
  input  logic [31:0] alu_result,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_result,
  output logic [31:0] es_pc,
  output logic [4:0]  es_dest,
  output logic        es_wen,
  output logic        es_exc_ov
);

  // Handshake: a transfer happens on a rising edge where the producer's valid
  // and the consumer's allowin are both high; valid never depends on allowin,
  // and a producer holding valid keeps its payload stable until accepted.

  logic        es_valid;
  logic        exc_block;
  logic        wen_q;
  logic        es_ready_go;
  logic        capture;
  logic        ov;
  logic [31:0] src0;
  logic [31:0] src1;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign capture        = ds_to_es_valid && es_allowin && !flush;
  assign ov             = es_valid && alu_overflow && !exc_block;
  assign es_exc_ov      = ov;
  assign es_wen         = es_valid && wen_q && !ov && !exc_block;
  assign es_to_ms_valid = es_valid && es_ready_go && !exc_block;
  assign es_result      = alu_result;

  always_comb begin
    src0 = '0;
    unique case (ds_src0_sel)
      2'b00:   src0 = ds_rs_val;
      2'b01:   src0 = {27'd0, ds_sa};
      2'b10:   src0 = ds_pc;
      default: src0 = '0;
    endcase
  end

  // Constant 8 pairs with src0 = pc to form link addresses.
  always_comb begin
    src1 = '0;
    unique case (ds_src1_sel)
      2'b00:   src1 = ds_rt_val;
      2'b01:   src1 = {{16{ds_imm[15]}}, ds_imm};
      2'b10:   src1 = {16'd0, ds_imm};
      default: src1 = 32'd8;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid  <= 1'b0;
      exc_block <= 1'b0;
      es_aluop  <= '0;
      es_scr0   <= '0;
      es_scr1   <= '0;
      es_pc     <= '0;
      es_dest   <= '0;
      wen_q     <= 1'b0;
    end else begin
      if (flush)
        es_valid <= 1'b0;
      else if (es_allowin)
        es_valid <= ds_to_es_valid;

      // Set once the faulting instruction leaves; flush wins over a same-cycle set.
      if (flush)
        exc_block <= 1'b0;
      else if (ov && ms_allowin)
        exc_block <= 1'b1;

      if (capture) begin
        es_aluop <= ds_aluop;
        es_scr0  <= src0;
        es_scr1  <= src1;
        es_pc    <= ds_pc;
        es_dest  <= ds_dest;
        wen_q    <= ds_wen;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed instructions, expected handovers queued
// by the driver and compared by an independent monitor at the memory-stage boundary.
module tb_ex_operand_stage;

  localparam int REC_W = 148;

  logic        clk;
  logic        reset;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [12:0] ds_aluop;
  logic [31:0] ds_rs_val;
  logic [31:0] ds_rt_val;
  logic [15:0] ds_imm;
  logic [4:0]  ds_sa;
  logic [31:0] ds_pc;
  logic [1:0]  ds_src0_sel;
  logic [1:0]  ds_src1_sel;
  logic [4:0]  ds_dest;
  logic        ds_wen;
  logic        flush;
  logic [31:0] es_scr0;
  logic [31:0] es_scr1;
  logic [12:0] es_aluop;
  logic        alu_overflow;
  logic [31:0] alu_result;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_result;
  logic [31:0] es_pc;
  logic [4:0]  es_dest;
  logic        es_wen;
  logic        es_exc_ov;

  logic [REC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_pushed = 0;
  int n_handover = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_aluop(ds_aluop), .ds_rs_val(ds_rs_val), .ds_rt_val(ds_rt_val), .ds_imm(ds_imm),
    .ds_sa(ds_sa), .ds_pc(ds_pc), .ds_src0_sel(ds_src0_sel), .ds_src1_sel(ds_src1_sel),
    .ds_dest(ds_dest), .ds_wen(ds_wen), .flush(flush), .es_scr0(es_scr0), .es_scr1(es_scr1),
    .es_aluop(es_aluop), .alu_overflow(alu_overflow), .alu_result(alu_result),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid), .es_result(es_result),
    .es_pc(es_pc), .es_dest(es_dest), .es_wen(es_wen), .es_exc_ov(es_exc_ov)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Small ALU model: bit0 add, bit1 sll, bit2 or; overflow only for trapping add.
  always_comb begin
    alu_result = '0;
    if (es_aluop[0])      alu_result = es_scr0 + es_scr1;
    else if (es_aluop[1]) alu_result = es_scr1 << es_scr0[4:0];
    else if (es_aluop[2]) alu_result = es_scr0 | es_scr1;
    alu_overflow = es_aluop[12] && es_aluop[0] && (es_scr0[31] == es_scr1[31])
                   && (alu_result[31] != es_scr0[31]);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Driver: mode 0 = forwarded (expectation queued), 1 = swallowed (checked
  // locally), 2 = captured but not expected to reach the memory stage.
  task automatic send(input logic [12:0] op, input logic [1:0] s0, input logic [1:0] s1,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic [4:0] sa, input logic [31:0] pc, input logic [4:0] dest,
                      input logic wen, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] eres, input logic eov, input int mode);
    logic accepted;
    int   n;
    ds_aluop = op; ds_src0_sel = s0; ds_src1_sel = s1; ds_rs_val = rs; ds_rt_val = rt;
    ds_imm = imm; ds_sa = sa; ds_pc = pc; ds_dest = dest; ds_wen = wen;
    ds_to_es_valid = 1'b1;
    if (mode == 0) begin
      exp_q.push_back({e0, e1, op, pc, dest, wen && !eov, eov, eres});
      n_pushed++;
    end
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 50) begin
      @(negedge clk);
      accepted = es_allowin;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) chk("accept_timeout", 32'(accepted), 32'd1);
    ds_to_es_valid = 1'b0;
    if (mode == 1) begin
      @(negedge clk);
      chk("swallow_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
      chk("swallow_wen", 32'(es_wen), 32'd0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_to_ms_valid"}, 32'(es_to_ms_valid), 32'd0);
    chk({tag, "_wen"}, 32'(es_wen), 32'd0);
    chk({tag, "_exc_ov"}, 32'(es_exc_ov), 32'd0);
    chk({tag, "_aluop"}, 32'(es_aluop), 32'd0);
    chk({tag, "_scr0"}, es_scr0, 32'd0);
    chk({tag, "_scr1"}, es_scr1, 32'd0);
    chk({tag, "_pc"}, es_pc, 32'd0);
    chk({tag, "_dest"}, 32'(es_dest), 32'd0);
    chk({tag, "_result"}, es_result, 32'd0);
    chk({tag, "_allowin"}, 32'(es_allowin), 32'd1);
  endtask

  // Scoreboard monitor: every handover to the memory stage pops one expectation.
  always @(negedge clk) begin
    logic [REC_W-1:0] rec;
    if (!reset && es_to_ms_valid && ms_allowin) begin
      n_handover++;
      if (exp_q.size() == 0) begin
        chk("unexpected_handover_pc", es_pc, 32'hFFFFFFFF);
      end else begin
        rec = exp_q.pop_front();
        chk("ho_scr0", es_scr0, rec[147:116]);
        chk("ho_scr1", es_scr1, rec[115:84]);
        chk("ho_aluop", 32'(es_aluop), 32'(rec[83:71]));
        chk("ho_pc", es_pc, rec[70:39]);
        chk("ho_dest", 32'(es_dest), 32'(rec[38:34]));
        chk("ho_wen", 32'(es_wen), 32'(rec[33]));
        chk("ho_exc_ov", 32'(es_exc_ov), 32'(rec[32]));
        chk("ho_result", es_result, rec[31:0]);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; flush = 1'b0; ms_allowin = 1'b1; ds_to_es_valid = 1'b0;
    ds_aluop = '0; ds_rs_val = '0; ds_rt_val = '0; ds_imm = '0; ds_sa = '0;
    ds_pc = '0; ds_src0_sel = '0; ds_src1_sel = '0; ds_dest = '0; ds_wen = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state("rst");
    @(posedge clk);
    #1;

    // Back-to-back stream: ADD, ADDIU (sign-extended imm), SLL
    send(13'h001, 2'b00, 2'b00, 32'd5, 32'd7, 16'h0000, 5'd0, 32'h100, 5'd3, 1'b1,
         32'd5, 32'd7, 32'd12, 1'b0, 0);
    send(13'h001, 2'b00, 2'b01, 32'd1, 32'd0, 16'hFFFF, 5'd0, 32'h104, 5'd4, 1'b1,
         32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 0);
    send(13'h002, 2'b01, 2'b00, 32'd0, 32'd3, 16'h0000, 5'd4, 32'h108, 5'd6, 1'b1,
         32'd4, 32'd3, 32'd48, 1'b0, 0);

    // Stall: memory stage refuses for three cycles
    send(13'h004, 2'b00, 2'b00, 32'hA0, 32'h0F, 16'h0000, 5'd0, 32'h10C, 5'd7, 1'b1,
         32'hA0, 32'h0F, 32'hAF, 1'b0, 0);
    ms_allowin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_allowin", 32'(es_allowin), 32'd0);
      chk("stall_to_ms_valid", 32'(es_to_ms_valid), 32'd1);
      chk("stall_scr0", es_scr0, 32'hA0);
      chk("stall_scr1", es_scr1, 32'h0F);
      chk("stall_result", es_result, 32'hAF);
    end
    @(posedge clk);
    #1 ms_allowin = 1'b1;
    send(13'h001, 2'b00, 2'b10, 32'd1, 32'd0, 16'h0002, 5'd0, 32'h110, 5'd8, 1'b0,
         32'd1, 32'd2, 32'd3, 1'b0, 0);

    // Overflow, two swallowed followers, flush, then normal flow resumes
    send(13'h1001, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1, 16'h0000, 5'd0, 32'h200, 5'd5, 1'b1,
         32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 0);
    send(13'h001, 2'b00, 2'b00, 32'd2, 32'd3, 16'h0000, 5'd0, 32'h204, 5'd9, 1'b1,
         32'd2, 32'd3, 32'd5, 1'b0, 1);
    send(13'h004, 2'b00, 2'b00, 32'd4, 32'd1, 16'h0000, 5'd0, 32'h208, 5'd10, 1'b1,
         32'd4, 32'd1, 32'd5, 1'b0, 1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    send(13'h001, 2'b00, 2'b00, 32'd10, 32'd20, 16'h0000, 5'd0, 32'h380, 5'd11, 1'b1,
         32'd10, 32'd20, 32'd30, 1'b0, 0);

    // Flush while stalled with decode offering an instruction
    send(13'h001, 2'b00, 2'b00, 32'd1, 32'd1, 16'h0000, 5'd0, 32'h400, 5'd12, 1'b1,
         32'd1, 32'd1, 32'd2, 1'b0, 2);
    ms_allowin = 1'b0;
    ds_aluop = 13'h001; ds_pc = 32'h500; ds_rs_val = 32'd9; ds_rt_val = 32'd9;
    ds_src0_sel = 2'b00; ds_src1_sel = 2'b00; ds_to_es_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("fstall_allowin", 32'(es_allowin), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("fstall_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("fstall_allowin_after", 32'(es_allowin), 32'd1);
    chk("fstall_not_captured_pc", es_pc, 32'h400);
    @(posedge clk);
    #1 ms_allowin = 1'b1;

    // Operand selects
    send(13'h001, 2'b10, 2'b11, 32'd0, 32'd0, 16'h0000, 5'd0, 32'hBFC00010, 5'd31, 1'b1,
         32'hBFC00010, 32'd8, 32'hBFC00018, 1'b0, 0);
    send(13'h001, 2'b00, 2'b10, 32'h10, 32'd0, 16'h8000, 5'd0, 32'h600, 5'd13, 1'b1,
         32'h10, 32'h00008000, 32'h00008010, 1'b0, 0);
    send(13'h001, 2'b11, 2'b00, 32'h1234, 32'h55, 16'h0000, 5'd0, 32'h604, 5'd14, 1'b1,
         32'd0, 32'h55, 32'h55, 1'b0, 0);

    // Reset mid-operation while blocked and holding a valid instruction
    send(13'h1001, 2'b00, 2'b00, 32'h80000000, 32'h80000000, 16'h0000, 5'd0, 32'h700,
         5'd15, 1'b1, 32'h80000000, 32'h80000000, 32'd0, 1'b1, 0);
    send(13'h001, 2'b00, 2'b00, 32'd1, 32'd1, 16'h0000, 5'd0, 32'h704, 5'd16, 1'b1,
         32'd1, 32'd1, 32'd2, 1'b0, 2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    send(13'h004, 2'b00, 2'b00, 32'hF0, 32'h0F, 16'h0000, 5'd0, 32'h800, 5'd17, 1'b1,
         32'hF0, 32'h0F, 32'hFF, 1'b0, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("handover_count", 32'(n_handover), 32'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
